fetch_align_queue: RTL and testbench
====================================

# fetch_align_queue

Parametrised instruction-fetch front end for the RV32IC core: issues word-aligned requests to the fetch buffer, stores returned halfwords in a DEPTH-entry circular queue, and realigns them into 16- and 32-bit instructions, including 32-bit instructions that straddle a word boundary. It sits between the fetch buffer and the decode stage. It replaces single-word fetch with prefetching, redirect flush with in-flight discard, and compressed/uncompressed alignment.

## Interface
- XLEN, 32: address width.
- DEPTH, 8: queue capacity in halfwords; power of 2, minimum 4.
- RESET_PC, 0: first fetch PC after reset; bit 0 must be 0.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- redirect_valid  in  1  flush and restart at redirect_pc. Upstream has already prioritised exception, mret and jump.
- redirect_pc  in  XLEN  new PC; bit 0 ignored.
- stall  in  1  decode not accepting; holds the head instruction.
- imem_valid  out  1  request pending.
- imem_addr  out  XLEN  word-aligned request address (bits 1:0 = 0).
- imem_ready  in  1  request completes this cycle; imem_rdata valid.
- imem_rdata  in  32  returned word; halfword 0 in bits 15:0.
- out_valid  out  1  out_instr/out_pc hold a complete instruction.
- out_pc  out  XLEN  PC of the head instruction.
- out_instr  out  32  instruction; compressed forms zero-extended to 32 bits.
- out_compressed  out  1  head is 16-bit (bits 1:0 != 2'b11).

## Operation
- State:
  - queue storage, rd_ptr and wr_ptr of log2(DEPTH)+1 bits (the extra bit distinguishes full from empty), count = wr_ptr - rd_ptr;
  - fetch_pc (next word address), out_pc register;
  - pending, kill and drop_low flags.
- Request issue: imem_valid=1 when pending, or when not pending and DEPTH - count >= 2. imem_addr = fetch_pc, held stable until imem_ready. At most one outstanding request.
- Response (imem_valid & imem_ready):
  - kill=1: discard the data and clear kill.
  - drop_low=1: push only halfword 1 and clear drop_low.
  - otherwise: push both halfwords.
  - In all non-killed cases fetch_pc += 4.
- Head decode:
  - head halfword bits 1:0 != 2'b11: 16-bit instruction, needs count >= 1.
  - otherwise: 32-bit instruction, needs count >= 2; upper halfword taken from rd_ptr+1 with wrap.
  - out_valid=1 only when the required halfwords are present. If only 1 of 2 is present, out_valid=0 and the queue waits.
- Pop: when out_valid & ~stall & ~redirect_valid, rd_ptr and out_pc advance by 1 halfword/2 for 16-bit and 2 halfwords/4 for 32-bit.
- Push and pop in the same cycle are both performed; count changes by pushed minus popped.
- Redirect (highest priority, same cycle as any push/pop):
  - rd_ptr = wr_ptr = 0, so the queue empties;
  - out_pc = redirect_pc & ~1; fetch_pc = redirect_pc & ~3; drop_low = redirect_pc[1];
  - if a request is pending and imem_ready=0 this cycle, kill=1;
  - any response arriving in the redirect cycle itself is discarded.
- Pointer arithmetic is modulo 2*DEPTH. A push never overflows because issue requires 2 free slots.
- When out_valid=0, out_instr = 32'h00000013 (nop) and out_compressed=0.

## Timing
- Reset values: imem_valid=0, imem_addr=RESET_PC & ~3, out_valid=0, out_pc=RESET_PC, out_instr=32'h00000013, out_compressed=0, queue empty, pending/kill=0, drop_low=RESET_PC[1].
- First cycle after reset: imem_valid=1.
- Response captured at edge N: out_valid=1 from cycle N+1 (registered queue, no bypass).
- Redirect asserted in cycle N: out_valid=0 in cycle N+1. The new request issues in N+1 if nothing is pending; otherwise it issues in the cycle after the killed response completes.
- Back-to-back: with imem_ready tied high and stall=0, a new request issues every cycle while space permits. Steady state is one instruction per cycle.
- rst asserted mid-transaction: all state returns to reset values at that edge. A subsequent imem_ready for the abandoned request is not expected; the fetch buffer is reset by the same rst.

## Test plan
- Reset, RESET_PC=0x100, memory returns 0x00A00093 then 0x00B00113 with imem_ready every cycle -> out_pc 0x100, 0x104; out_compressed=0; imem_addr 0x100, 0x104, 0x108.
- Word 0x00130001 at 0x200 (c.nop, then low half of 0x00000013), next word 0x00010000 -> c.nop at 0x200 (out_instr=0x00000001); 32-bit 0x00000013 at 0x202 appears only after the second word arrives.
- Redirect to 0x302 -> request to 0x300; halfword 0 dropped; first out_pc=0x302 with instruction from bits 31:16.
- Redirect while a request is pending with imem_ready delayed 3 cycles -> that response is discarded; the next imem_addr is the redirect word; no stale out_valid.
- stall held 10 cycles with DEPTH=8 -> at most 8 halfwords queued; imem_valid drops when fewer than 2 slots are free; no data is lost after release.
- Pop and push in the same cycle with the rd_ptr wrap from 7 to 0 -> count and out_pc correct; a 32-bit instruction spanning slots 7 and 0 is assembled correctly.

Source files
------------

// File: rtl/fetch_align_queue.sv
// ============================================================================
// fetch_align_queue : prefetching RV32IC fetch front end, 16/32-bit realignment
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_align_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 8,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            imem_valid,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic            out_compressed
);

  localparam int            AW      = $clog2(DEPTH);
  localparam int            PW      = AW + 1;
  localparam logic [PW-1:0] C_ONE   = PW'(1);
  localparam logic [PW-1:0] C_TWO   = PW'(2);
  localparam logic [PW-1:0] C_DEPTH = PW'(DEPTH);
  localparam logic [31:0]   C_NOP   = 32'h0000_0013;

  logic [15:0]     mem_q [DEPTH];
  logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, out_pc_q, out_pc_d, req_addr_q;
  logic            pending_q, pending_d, kill_q, kill_d, drop_low_q, drop_low_d;

  logic [PW-1:0]   count, free_slots, rd_next1;
  logic [15:0]     hw0, hw1, wdata0;
  logic            is32, resp, pop, we0, we1;

  always_comb begin
    count      = wr_q - rd_q;
    free_slots = C_DEPTH - count;
    rd_next1   = rd_q + C_ONE;
    hw0        = mem_q[rd_q[AW-1:0]];
    hw1        = mem_q[rd_next1[AW-1:0]];
    is32       = (hw0[1:0] == 2'b11);

    out_valid      = is32 ? (count >= C_TWO) : (count != '0);
    out_instr      = !out_valid ? C_NOP : (is32 ? {hw1, hw0} : {16'h0000, hw0});
    out_compressed = out_valid & ~is32;
    out_pc         = out_pc_q;

    // A held request keeps its address even after a redirect moves fetch_pc.
    imem_valid = ~rst & (pending_q | (free_slots >= C_TWO));
    imem_addr  = pending_q ? req_addr_q : fetch_pc_q;

    resp = imem_valid & imem_ready;
    pop  = out_valid & ~stall & ~redirect_valid;
  end

  always_comb begin
    rd_d       = pop ? (rd_q + (is32 ? C_TWO : C_ONE)) : rd_q;
    out_pc_d   = pop ? (out_pc_q + (is32 ? XLEN'(4) : XLEN'(2))) : out_pc_q;
    wr_d       = wr_q;
    fetch_pc_d = fetch_pc_q;
    kill_d     = kill_q;
    drop_low_d = drop_low_q;
    pending_d  = imem_valid & ~imem_ready;
    we0        = 1'b0;
    we1        = 1'b0;
    wdata0     = imem_rdata[15:0];

    if (resp) begin
      if (kill_q) begin
        kill_d = 1'b0;
      end else if (drop_low_q) begin
        we0        = 1'b1;
        wdata0     = imem_rdata[31:16];
        wr_d       = wr_q + C_ONE;
        drop_low_d = 1'b0;
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end else begin
        we0        = 1'b1;
        we1        = 1'b1;
        wr_d       = wr_q + C_TWO;
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
    end

    if (redirect_valid) begin
      rd_d       = '0;
      wr_d       = '0;
      we0        = 1'b0;
      we1        = 1'b0;
      out_pc_d   = {redirect_pc[XLEN-1:1], 1'b0};
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      drop_low_d = redirect_pc[1];
      kill_d     = imem_valid & ~imem_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q       <= '0;
      wr_q       <= '0;
      fetch_pc_q <= {RESET_PC[XLEN-1:2], 2'b00};
      out_pc_q   <= RESET_PC;
      req_addr_q <= {RESET_PC[XLEN-1:2], 2'b00};
      pending_q  <= 1'b0;
      kill_q     <= 1'b0;
      drop_low_q <= RESET_PC[1];
    end else begin
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      fetch_pc_q <= fetch_pc_d;
      out_pc_q   <= out_pc_d;
      req_addr_q <= imem_addr;
      pending_q  <= pending_d;
      kill_q     <= kill_d;
      drop_low_q <= drop_low_d;
    end
  end

  // Storage needs no reset: empty pointers keep stale entries invisible.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (we0) mem_q[wr_q[AW-1:0]] <= wdata0;
      if (we1) mem_q[rd_wrap(wr_q + C_ONE)] <= imem_rdata[31:16];
    end
  end

  function automatic logic [AW-1:0] rd_wrap(input logic [PW-1:0] p);
    return p[AW-1:0];
  endfunction

endmodule

`default_nettype wire

// File: tb/tb_fetch_align_queue.sv
// Directed bench for fetch_align_queue: per-cycle vector table plus
// hand-written redirect/kill, stall-backpressure, wrap and reset sequences.
`default_nettype none

module tb_fetch_align_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_compressed;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_align_queue #(.XLEN(32), .DEPTH(8), .RESET_PC(32'h100)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .imem_valid(imem_valid), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_compressed(out_compressed)
  );

  // Instruction memory image; unlisted words are addi x0,x0,<addr[11:0]>.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h100: return 32'h00A0_0093;
      32'h104: return 32'h00B0_0113;
      32'h108: return 32'h00C0_0193;
      32'h200: return 32'h0013_0001;
      32'h204: return 32'h0001_0000;
      32'h300: return 32'h4505_FFFF;
      32'h400: return 32'h0010_0093;
      32'h600: return 32'h0020_0113;
      32'h800: return 32'h0001_FFFF;
      default: return {a[11:0], 20'h00013};
    endcase
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        st;
    logic        rdy;
    logic        e_iv;
    logic [31:0] e_addr;
    logic        e_ov;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_comp;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rv, input logic [31:0] rp, input logic st, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rp;
    stall          = st;
    imem_ready     = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic ov, input logic [31:0] pc,
                         input logic [31:0] ins, input logic comp);
    chk({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, ov});
    chk({tag, ".out_pc"}, out_pc, pc);
    chk({tag, ".out_instr"}, out_instr, ins);
    chk({tag, ".out_compressed"}, {31'b0, out_compressed}, {31'b0, comp});
  endtask

  initial begin
    //            rv  rpc      st rdy  iv addr     ov pc       instr         comp
    tbl[0]  = '{1'b0, 32'h0,   0, 1,   1, 32'h100, 0, 32'h100, 32'h00000013, 0};
    tbl[1]  = '{1'b0, 32'h0,   0, 1,   1, 32'h104, 1, 32'h100, 32'h00A00093, 0};
    tbl[2]  = '{1'b0, 32'h0,   0, 1,   1, 32'h108, 1, 32'h104, 32'h00B00113, 0};
    tbl[3]  = '{1'b0, 32'h0,   0, 1,   1, 32'h10C, 1, 32'h108, 32'h00C00193, 0};
    tbl[4]  = '{1'b1, 32'h200, 0, 1,   1, 32'h110, 1, 32'h10C, 32'h10C00013, 0};
    tbl[5]  = '{1'b0, 32'h0,   0, 1,   1, 32'h200, 0, 32'h200, 32'h00000013, 0};
    tbl[6]  = '{1'b0, 32'h0,   0, 0,   1, 32'h204, 1, 32'h200, 32'h00000001, 1};
    tbl[7]  = '{1'b0, 32'h0,   0, 1,   1, 32'h204, 0, 32'h202, 32'h00000013, 0};
    tbl[8]  = '{1'b1, 32'h302, 0, 1,   1, 32'h208, 1, 32'h202, 32'h00000013, 0};
    tbl[9]  = '{1'b0, 32'h0,   0, 1,   1, 32'h300, 0, 32'h302, 32'h00000013, 0};
    tbl[10] = '{1'b0, 32'h0,   0, 1,   1, 32'h304, 1, 32'h302, 32'h00004505, 1};
    tbl[11] = '{1'b0, 32'h0,   0, 1,   1, 32'h308, 1, 32'h304, 32'h30400013, 0};

    rst = 1'b1;
    step(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset.imem_valid", {31'b0, imem_valid}, 32'd0);
    chk("reset.imem_addr", imem_addr, 32'h100);
    chk_out("reset", 1'b0, 32'h100, 32'h00000013, 1'b0);
    rst = 1'b0;

    // Straight-line fetch, compressed/straddling alignment, odd-halfword redirect
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].rv, tbl[i].rpc, tbl[i].st, tbl[i].rdy);
      chk($sformatf("vec%0d.imem_valid", i), {31'b0, imem_valid}, {31'b0, tbl[i].e_iv});
      chk($sformatf("vec%0d.imem_addr", i), imem_addr, tbl[i].e_addr);
      chk_out($sformatf("vec%0d", i), tbl[i].e_ov, tbl[i].e_pc, tbl[i].e_instr, tbl[i].e_comp);
      tick();
    end

    // Redirect while a request is held; its late response must be discarded
    step(1'b1, 32'h400, 1'b0, 1'b1); tick();
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("kill.req_addr", imem_addr, 32'h400);
    tick();
    step(1'b0, 32'h0, 1'b0, 1'b0); tick();
    step(1'b1, 32'h600, 1'b0, 1'b0);
    chk("kill.held_addr", imem_addr, 32'h400);
    tick();
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("kill.still_held", imem_addr, 32'h400);
    chk("kill.valid_in_kill", {31'b0, imem_valid}, 32'd1);
    chk("kill.no_stale0", {31'b0, out_valid}, 32'd0);
    tick();
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("kill.new_addr", imem_addr, 32'h600);
    chk("kill.no_stale1", {31'b0, out_valid}, 32'd0);
    tick();
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk_out("kill.first", 1'b1, 32'h600, 32'h00200113, 1'b0);
    tick();

    // Stall for 10 cycles: queue fills to DEPTH, then issue stops
    step(1'b1, 32'h700, 1'b0, 1'b1); tick();
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1);
      chk($sformatf("stall%0d.imem_valid", k), {31'b0, imem_valid}, (k <= 4) ? 32'd1 : 32'd0);
      if (k >= 2) chk_out($sformatf("stall%0d", k), 1'b1, 32'h700, 32'h70000013, 1'b0);
      tick();
    end
    for (int k = 0; k < 8; k++) begin
      logic [31:0] pc;
      pc = 32'h700 + 32'(4 * k);
      step(1'b0, 32'h0, 1'b0, 1'b1);
      chk_out($sformatf("drain%0d", k), 1'b1, pc, {pc[11:0], 20'h00013}, 1'b0);
      if (k == 0) chk("drain0.imem_valid", {31'b0, imem_valid}, 32'd0);
      if (k == 1) chk("drain1.imem_addr", imem_addr, 32'h710);
      tick();
    end

    // Odd start puts a 32-bit instruction across queue slots 7 and 0
    step(1'b1, 32'h802, 1'b0, 1'b1); tick();
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("wrap.addr", imem_addr, 32'h800);
    chk("wrap.empty", {31'b0, out_valid}, 32'd0);
    tick();
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk_out("wrap.cnop", 1'b1, 32'h802, 32'h00000001, 1'b1);
    tick();
    for (int k = 0; k < 6; k++) begin
      logic [31:0] pc;
      pc = 32'h804 + 32'(4 * k);
      step(1'b0, 32'h0, 1'b0, 1'b1);
      chk_out($sformatf("wrap%0d", k), 1'b1, pc, {pc[11:0], 20'h00013}, 1'b0);
      tick();
    end

    // Reset while a request is outstanding
    step(1'b0, 32'h0, 1'b0, 1'b0); tick();
    rst = 1'b1;
    tick();
    chk("rst_mid.imem_valid", {31'b0, imem_valid}, 32'd0);
    chk("rst_mid.imem_addr", imem_addr, 32'h100);
    chk_out("rst_mid", 1'b0, 32'h100, 32'h00000013, 1'b0);
    rst = 1'b0;
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("rst_mid.reissue", {31'b0, imem_valid}, 32'd1);
    chk("rst_mid.reissue_addr", imem_addr, 32'h100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
